// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder computing {carry_out, sum} = a + b + carry_in.
// One DIGIT-wide adder slice is reused for WIDTH/DIGIT cycles through a
// registered carry; operands and results move through valid/ready handshakes.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

    // Reject parameter sets that would leave a partial digit at the top.
    generate
        if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_adder: need 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_a_sh;
    logic [WIDTH-1:0]  r_b_sh;
    logic [WIDTH-1:0]  r_sum;
    logic              r_carry;
    logic              r_cout;
    logic [CNT_W-1:0]  r_cnt;

    logic [DIGIT:0]       w_digit_sum;
    logic [WIDTH+DIGIT-1:0] w_sum_cat;
    logic [WIDTH-1:0]     w_sum_shifted;
    logic                 w_last;

    // One digit slice: low DIGIT bits of each operand plus the running carry.
    always_comb begin
        w_digit_sum   = {1'b0, r_a_sh[DIGIT-1:0]} + {1'b0, r_b_sh[DIGIT-1:0]}
                      + {{DIGIT{1'b0}}, r_carry};
        // New digit enters at the MSB end; concatenating first keeps this legal when DIGIT == WIDTH.
        w_sum_cat     = {w_digit_sum[DIGIT-1:0], r_sum};
        w_sum_shifted = w_sum_cat[WIDTH+DIGIT-1:DIGIT];
        w_last        = (r_cnt == LAST_STEP);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and handshake outputs decoded from state.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand load, digit-serial shift/accumulate and final carry capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_carry <= carry_in;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_sum   <= w_sum_shifted;
                    r_carry <= w_digit_sum[DIGIT];
                    r_a_sh  <= r_a_sh >> DIGIT;
                    r_b_sh  <= r_b_sh >> DIGIT;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_cout <= w_digit_sum[DIGIT];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum       = r_sum;
    assign carry_out = r_cout;

endmodule
